ccu_key_sched: RTL

Nibble-serial key-schedule stage for the teeny-tiny AES datapath. It sits directly upstream of the `ccu` round core. It accepts a 16-bit Simplified-AES (S-AES) cipher key as four 4-bit nibbles and expands it into three 16-bit round keys (K0, K1, K2). It then streams the round keys to the core one nibble per handshake, which removes key expansion from the core and from the 4-bit pin budget.

---
 rtl/ccu_key_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ccu_key_sched.sv
// Nibble-serial S-AES key schedule: loads a 16-bit key as four nibbles, expands it
// into three round keys and streams them out one nibble per handshake.
module ccu_key_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] rk_out,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [1:0] rk_round,
  output logic       rk_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXP1   = 2'd1,
    EXP2   = 2'd2,
    STREAM = 2'd3
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
      4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
      4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  4'hF: r = 4'h7;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // SubNib(RotNib(b)): swapping the nibbles first means the low nibble feeds the high S-box.
  function automatic logic [7:0] sub_rot(input logic [7:0] b);
    return {sbox(b[3:0]), sbox(b[7:4])};
  endfunction

  function automatic logic [3:0] nib_at(input logic [47:0] word, input logic [3:0] idx);
    logic [47:0] sh;
    sh = word << {idx, 2'b00};
    return sh[47:44];
  endfunction

  state_t      state_r, state_s;
  logic [15:0] key_r, key_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [7:0]  w2_r, w3_r, w4_r, w5_r;
  logic [7:0]  w2_s, w3_s, w4_s, w5_s;
  logic [3:0]  idx_r, idx_s;
  logic        stream_s;
  logic [3:0]  rk_out_s;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s  = state_r;
    key_s    = key_r;
    cnt_s    = cnt_r;
    w2_s     = w2_r;
    w3_s     = w3_r;
    w4_s     = w4_r;
    w5_s     = w5_r;
    idx_s    = idx_r;
    case (state_r)
      LOAD: begin
        if (key_valid) begin
          key_s = {key_r[11:0], key_in};
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = EXP1;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      EXP1: begin
        w2_s    = key_r[15:8] ^ 8'h80 ^ sub_rot(key_r[7:0]);
        w3_s    = w2_s ^ key_r[7:0];
        state_s = EXP2;
      end
      EXP2: begin
        w4_s    = w2_r ^ 8'h30 ^ sub_rot(w3_r);
        w5_s    = w4_s ^ w3_r;
        idx_s   = 4'd0;
        state_s = STREAM;
      end
      STREAM: begin
        if (rk_ready) begin
          idx_s = idx_r + 4'd1;
          if (idx_r == 4'd11) begin
            state_s = LOAD;
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = LOAD;
    endcase

    // Outputs are registered from the next state so no input reaches a pin combinationally.
    stream_s = (state_s == STREAM);
    if (stream_s) begin
      rk_out_s = nib_at({key_s, w2_s, w3_s, w4_s, w5_s}, idx_s);
    end else begin
      rk_out_s = 4'd0;
    end
  end

  // State, key/expansion registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= LOAD;
      key_r     <= 16'd0;
      cnt_r     <= 2'd0;
      w2_r      <= 8'd0;
      w3_r      <= 8'd0;
      w4_r      <= 8'd0;
      w5_r      <= 8'd0;
      idx_r     <= 4'd0;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_out    <= 4'd0;
      rk_round  <= 2'd0;
      rk_last   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      key_r     <= key_s;
      cnt_r     <= cnt_s;
      w2_r      <= w2_s;
      w3_r      <= w3_s;
      w4_r      <= w4_s;
      w5_r      <= w5_s;
      idx_r     <= idx_s;
      key_ready <= (state_s == LOAD);
      busy      <= (state_s != LOAD);
      rk_valid  <= stream_s;
      rk_out    <= rk_out_s;
      rk_round  <= stream_s ? idx_s[3:2] : 2'd0;
      rk_last   <= stream_s && (idx_s == 4'd11);
    end
  end

endmodule
